// File: rtl/sdram_burst_bridge.sv
// Host burst command/data port to sdram_controller req/ack, with a first-word-fall-through write FIFO.
// Define SDRAM_BRIDGE_PAGE_SPLIT_EN to split page-crossing bursts in two; otherwise they are rejected.
module sdram_burst_bridge #(
  parameter int DW         = 16,
  parameter int AW         = 24,
  parameter int FIFO_DEPTH = 256,
  parameter int MAX_BURST  = 256,
  parameter int COL_W      = 9
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AW-1:0]               cmd_addr,
  input  logic [9:0]                  cmd_len,
  input  logic                        wr_data_valid,
  output logic                        wr_data_ready,
  input  logic [DW-1:0]               wr_data,
  output logic                        rd_data_valid,
  output logic [DW-1:0]               rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        sdram_init_done,
  output logic                        sdram_wr_req,
  input  logic                        sdram_wr_ack,
  output logic [23:0]                 sdram_wr_addr,
  output logic [9:0]                  sdram_wr_burst,
  output logic [DW-1:0]               sdram_din,
  output logic                        sdram_rd_req,
  input  logic                        sdram_rd_ack,
  output logic [23:0]                 sdram_rd_addr,
  output logic [9:0]                  sdram_rd_burst,
  input  logic [DW-1:0]               sdram_dout
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int PAGE = 1 << COL_W;

  // state     | meaning
  // IDLE      | accept a command when the controller is initialised
  // CHECK     | validate length, size first sub-burst
  // WAIT_DATA | wait until the FIFO holds the whole write sub-burst
  // WR_REQ    | write request held until first ack
  // WR_XFER   | write words stream out of the FIFO while ack is high
  // RD_REQ    | read request held until first ack
  // RD_XFER   | read words stream back while ack is high
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE, CHECK, WAIT_DATA, WR_REQ, WR_XFER, RD_REQ, RD_XFER, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [9:0]    len_q, len_d;
  logic [9:0]    len1_q, len1_d;
  logic          write_q, write_d;
  logic          wr_req_q, wr_req_d;
  logic          rd_req_q, rd_req_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          run_q;
  logic          end_sub;
  logic [10:0]   room;
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
  logic [9:0]    len2_q, len2_d;
  logic [9:0]    len1_w;
`endif

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          push, pop, full;

  assign full  = (count_q == LW'(FIFO_DEPTH));
  assign push  = wr_data_valid && wr_data_ready;
  assign pop   = sdram_wr_ack && (state_q == WR_REQ || state_q == WR_XFER) && (count_q != '0);

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // words left in the page starting at the command address
  assign room = 11'(PAGE) - 11'(addr_q[COL_W-1:0]);
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
  assign len1_w = ({1'b0, len_q} < room) ? len_q : room[9:0];
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    len1_d   = len1_q;
    write_d  = write_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    err_d    = 1'b0;
    end_sub  = 1'b0;
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
    len2_d   = len2_q;
`endif
    rd_valid_d = sdram_rd_ack && (state_q == RD_REQ || state_q == RD_XFER);
    rd_data_d  = sdram_rd_ack ? sdram_dout : rd_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          write_d = cmd_write;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (len_q == '0 || 32'(len_q) > MAX_BURST) begin
          err_d   = 1'b1;
          state_d = IDLE;
`ifndef SDRAM_BRIDGE_PAGE_SPLIT_EN
        end else if ({1'b0, len_q} > room) begin
          err_d   = 1'b1;
          state_d = IDLE;
`endif
        end else begin
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
          len1_d = len1_w;
          len2_d = len_q - len1_w;
`else
          len1_d = len_q;
`endif
          if (!write_q) begin
            rd_req_d = 1'b1;
            state_d  = RD_REQ;
          end else if (32'(count_q) >= 32'(len1_d)) begin
            wr_req_d = 1'b1;
            state_d  = WR_REQ;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (32'(count_q) >= 32'(len1_q)) begin
          wr_req_d = 1'b1;
          state_d  = WR_REQ;
        end
      end
      WR_REQ: begin
        if (sdram_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = WR_XFER;
        end
      end
      RD_REQ: begin
        if (sdram_rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = RD_XFER;
        end
      end
      WR_XFER: end_sub = !sdram_wr_ack;
      RD_XFER: end_sub = !sdram_rd_ack;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (end_sub) begin
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
      if (len2_q != '0) begin
        addr_d = addr_q + AW'(len1_q);
        len1_d = len2_q;
        len2_d = '0;
        if (write_q) begin
          state_d = WAIT_DATA;
        end else begin
          rd_req_d = 1'b1;
          state_d  = RD_REQ;
        end
      end else begin
        state_d = DONE;
      end
`else
      state_d = DONE;
`endif
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      len1_q     <= '0;
      write_q    <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
      len2_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      len1_q     <= len1_d;
      write_q    <= write_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      run_q      <= 1'b1;
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
      len2_q     <= len2_d;
`endif
    end
  end

  // run_q keeps the handshake readies low while reset is held
  assign cmd_ready      = run_q && (state_q == IDLE) && sdram_init_done;
  assign wr_data_ready  = run_q && !full;
  assign rd_data_valid  = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign fifo_level     = count_q;
  assign sdram_wr_req   = wr_req_q;
  assign sdram_wr_addr  = 24'(addr_q);
  assign sdram_wr_burst = len1_q;
  assign sdram_din      = (state_q == WR_REQ || state_q == WR_XFER) ? mem_q[rd_ptr_q] : '0;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_rd_addr  = 24'(addr_q);
  assign sdram_rd_burst = len1_q;

endmodule

// File: tb/tb_sdram_burst_bridge.sv
// Directed bench for sdram_burst_bridge: behavioural controller model plus write/read scoreboards.
module tb_sdram_burst_bridge;
  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [23:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic        wr_data_valid, wr_data_ready;
  logic [15:0] wr_data;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic        busy, done, err;
  logic [8:0]  fifo_level;
  logic        sdram_init_done;
  logic        sdram_wr_req, sdram_wr_ack;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic        sdram_rd_req, sdram_rd_ack;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic [15:0] sdram_dout;

  always #5 sys_clk = ~sys_clk;

  sdram_burst_bridge dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .fifo_level(fifo_level),
    .sdram_init_done(sdram_init_done),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst), .sdram_din(sdram_din),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst), .sdram_dout(sdram_dout)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          rd_cnt = 0;
  logic        rd_ack_prev = 1'b0;
  logic [15:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [34:0] req_log[$];
  logic [15:0] mem[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rd_data_valid || rd_ack_prev) chk("rd_valid_latency", rd_data_valid, rd_ack_prev);
    if (rd_data_valid) begin
      rd_cnt++;
      chk("rd_word_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
    end
    rd_ack_prev = sdram_rd_ack;
  end

  // controller model: ack one cycle after req, held for exactly burst cycles
  initial begin : ctrl_model
    logic [23:0] a;
    logic [9:0]  b;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    sdram_dout   = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (rst_n && sdram_wr_req) begin
        a = sdram_wr_addr;
        b = sdram_wr_burst;
        req_log.push_back({1'b1, a, b});
        @(posedge sys_clk); #1;
        for (int k = 0; k < int'(b); k++) begin
          if (!rst_n) break;
          sdram_wr_ack = 1'b1;
          chk("wr_word_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) chk("wr_din", sdram_din, exp_wr.pop_front());
          mem[int'(a) + k] = sdram_din;
          @(posedge sys_clk); #1;
        end
        sdram_wr_ack = 1'b0;
      end else if (rst_n && sdram_rd_req) begin
        a = sdram_rd_addr;
        b = sdram_rd_burst;
        req_log.push_back({1'b0, a, b});
        @(posedge sys_clk); #1;
        for (int k = 0; k < int'(b); k++) begin
          if (!rst_n) break;
          sdram_rd_ack = 1'b1;
          sdram_dout   = mem.exists(int'(a) + k) ? mem[int'(a) + k] : 16'h0000;
          @(posedge sys_clk); #1;
        end
        sdram_rd_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [15:0] w);
    @(negedge sys_clk);
    chk("push_ready", wr_data_ready, 1);
    wr_data_valid = 1'b1;
    wr_data       = w;
    @(posedge sys_clk);
    exp_wr.push_back(w);
    #1 wr_data_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic wr, input logic [23:0] a, input logic [9:0] l);
    int n;
    n = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("cmd_handshake", n < 50, 1);
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin : stim
    logic [15:0] wbuf [8];
    int          n, d0, e0, r0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0;
    sdram_init_done = 1'b1;
    for (int i = 0; i < 8; i++) wbuf[i] = 16'hC000 | 16'(i * 16'h0123);

    repeat (3) @(negedge sys_clk);
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_data_ready, 0);
    chk("rst_done_err", {done, err, rd_data_valid}, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // single-word write, data prefilled
    push_word(16'hA55A);
    @(negedge sys_clk);
    chk("t1_level", fifo_level, 1);
    issue_cmd(1'b1, 24'h000010, 10'd1);
    chk("t1_req_check_cycle", sdram_wr_req, 0);
    @(posedge sys_clk); #1;
    chk("t1_req_latency", sdram_wr_req, 1);
    chk("t1_addr", sdram_wr_addr, 24'h000010);
    chk("t1_burst", sdram_wr_burst, 1);
    wait_done("t1_done");
    chk("t1_ready_in_done", cmd_ready, 0);
    @(negedge sys_clk);
    chk("t1_ready_after", cmd_ready, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_req_cnt", req_log.size(), 1);
    chk("t1_req", req_log.pop_front(), {1'b1, 24'h000010, 10'd1});
    chk("t1_level_end", fifo_level, 0);

    // write issued before its data
    issue_cmd(1'b1, 24'h000100, 10'd8);
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge sys_clk);
      chk("t2_req_early", sdram_wr_req, 0);
      chk("t2_level", fifo_level, i);
      push_word(wbuf[i]);
    end
    wait_done("t2_done");
    @(negedge sys_clk);
    chk("t2_req", req_log.pop_front(), {1'b1, 24'h000100, 10'd8});
    chk("t2_level_end", fifo_level, 0);
    chk("t2_wr_consumed", exp_wr.size(), 0);

    // read back first four words
    for (int i = 0; i < 4; i++) exp_rd.push_back(wbuf[i]);
    r0 = rd_cnt;
    issue_cmd(1'b0, 24'h000100, 10'd4);
    wait_done("t3_done");
    @(negedge sys_clk);
    chk("t3_rd_cnt", rd_cnt - r0, 4);
    chk("t3_rd_consumed", exp_rd.size(), 0);
    chk("t3_req", req_log.pop_front(), {1'b0, 24'h000100, 10'd4});

    // page-crossing read
    for (int i = 0; i < 4; i++) mem[int'(24'h0001FE) + i] = 16'hBEE0 + 16'(i);
    d0 = done_cnt;
    e0 = err_cnt;
    r0 = rd_cnt;
`ifdef SDRAM_BRIDGE_PAGE_SPLIT_EN
    for (int i = 0; i < 4; i++) exp_rd.push_back(16'hBEE0 + 16'(i));
    issue_cmd(1'b0, 24'h0001FE, 10'd4);
    wait_done("t4_done");
    @(negedge sys_clk);
    chk("t4_req_cnt", req_log.size(), 2);
    chk("t4_req_a", req_log.pop_front(), {1'b0, 24'h0001FE, 10'd2});
    chk("t4_req_b", req_log.pop_front(), {1'b0, 24'h000200, 10'd2});
    chk("t4_rd_cnt", rd_cnt - r0, 4);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_err_cnt", err_cnt - e0, 0);
`else
    issue_cmd(1'b0, 24'h0001FE, 10'd4);
    repeat (4) @(negedge sys_clk);
    chk("t4_err_cnt", err_cnt - e0, 1);
    chk("t4_req_cnt", req_log.size(), 0);
    chk("t4_done_cnt", done_cnt - d0, 0);
    chk("t4_busy", busy, 0);
`endif

    // rejected lengths and a command while the controller is not initialised
    e0 = err_cnt;
    issue_cmd(1'b1, 24'h000020, 10'd0);
    repeat (4) @(negedge sys_clk);
    chk("t5_err_len0", err_cnt - e0, 1);
    issue_cmd(1'b0, 24'h000020, 10'd257);
    repeat (4) @(negedge sys_clk);
    chk("t5_err_len257", err_cnt - e0, 2);
    @(negedge sys_clk);
    sdram_init_done = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000040; cmd_len = 10'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("t5_ready_no_init", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    sdram_init_done = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("t5_err_total", err_cnt - e0, 2);
    chk("t5_req_cnt", req_log.size(), 0);
    chk("t5_busy", busy, 0);

    // reset during a write transfer
    for (int i = 0; i < 16; i++) push_word(16'h5000 + 16'(i));
    issue_cmd(1'b1, 24'h000300, 10'd16);
    n = 0;
    while (!sdram_wr_ack && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t6_ack_seen", sdram_wr_ack, 1);
    repeat (3) @(negedge sys_clk);
    chk("t6_req", req_log.pop_front(), {1'b1, 24'h000300, 10'd16});
    chk("t6_level_before", fifo_level != 0, 1);
    chk("t6_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_rst", sdram_wr_req, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_level_rst", fifo_level, 0);
    repeat (2) @(posedge sys_clk);
    exp_wr.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    d0 = done_cnt;
    push_word(16'h7777);
    push_word(16'h8888);
    issue_cmd(1'b1, 24'h000400, 10'd2);
    wait_done("t6_fresh_done");
    @(negedge sys_clk);
    chk("t6_fresh_req", req_log.pop_front(), {1'b1, 24'h000400, 10'd2});
    chk("t6_fresh_level", fifo_level, 0);
    chk("t6_fresh_consumed", exp_wr.size(), 0);
    chk("t6_fresh_done_cnt", done_cnt - d0, 1);

    repeat (3) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
